// File: rtl/rv32i_uart_loader.sv
// UART boot loader: receives an 0xA5-framed, checksummed program image, writes it as
// little-endian 32-bit words into instruction memory and releases the core once verified.
module rv32i_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ROM_BYTES    = 1024,
  localparam int AW          = $clog2(ROM_BYTES)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_uart_rx,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [31:0]   o_wr_data,
  output logic          o_core_rst_n,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int WW = AW - 2;
  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_LEN0, L_LEN1, L_DATA, L_CSUM, L_DONE, L_ERROR} ld_state_t;

  rx_state_t     r_rx_state, w_rx_next;
  logic          r_rx_meta, r_rx_sync;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_rx_shift;
  logic          w_half_tick, w_bit_tick, w_byte_vld, w_frame_err;
  logic [7:0]    w_rx_byte;

  ld_state_t     r_ld_state, w_ld_next;
  logic [15:0]   r_len;
  logic [7:0]    r_sum;
  logic [WW-1:0] r_word_idx;
  logic [1:0]    r_byte_cnt;
  logic [23:0]   r_word;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [31:0]   r_wr_data;
  logic [15:0]   w_len_full;
  logic          w_last_word, w_in_frame;

  assign w_half_tick = (r_clk_cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign w_bit_tick  = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_byte_vld  = (r_rx_state == RX_STOP) && w_bit_tick && r_rx_sync;
  assign w_frame_err = (r_rx_state == RX_STOP) && w_bit_tick && !r_rx_sync;
  assign w_rx_byte   = r_rx_shift;

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START;
      // A line that is high again at mid start bit was only a glitch
      RX_START: if (w_half_tick) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_bit_tick && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
      RX_STOP:  if (w_bit_tick) w_rx_next = RX_IDLE;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta  <= i_uart_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_state <= w_rx_next;
      if (r_rx_state == RX_IDLE || w_rx_next != r_rx_state || w_bit_tick)
        r_clk_cnt <= '0;
      else
        r_clk_cnt <= r_clk_cnt + CW'(1);
      if (r_rx_state == RX_IDLE)
        r_bit_idx <= '0;
      else if (r_rx_state == RX_DATA && w_bit_tick) begin
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        r_bit_idx  <= r_bit_idx + 3'd1;
      end
    end
  end

  assign w_len_full  = {w_rx_byte, r_len[7:0]};
  assign w_last_word = (16'(r_word_idx) == r_len - 16'd1);
  assign w_in_frame  = (r_ld_state == L_LEN0) || (r_ld_state == L_LEN1) ||
                       (r_ld_state == L_DATA) || (r_ld_state == L_CSUM);

  always_comb begin
    w_ld_next = r_ld_state;
    if (w_frame_err && w_in_frame)
      w_ld_next = L_ERROR;
    else if (w_byte_vld) begin
      case (r_ld_state)
        L_IDLE, L_DONE, L_ERROR: if (w_rx_byte == MAGIC) w_ld_next = L_LEN0;
        L_LEN0: w_ld_next = L_LEN1;
        L_LEN1: begin
          if ({1'b0, w_len_full} > 17'(ROM_BYTES / 4)) w_ld_next = L_ERROR;
          else if (w_len_full == 16'd0)                w_ld_next = L_CSUM;
          else                                         w_ld_next = L_DATA;
        end
        L_DATA: if (r_byte_cnt == 2'd3 && w_last_word) w_ld_next = L_CSUM;
        L_CSUM: w_ld_next = (w_rx_byte == r_sum) ? L_DONE : L_ERROR;
        default: w_ld_next = L_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ld_state <= L_IDLE;
      r_len      <= '0;
      r_sum      <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_ld_state <= w_ld_next;
      r_wr_en    <= 1'b0;
      if (w_byte_vld) begin
        case (r_ld_state)
          L_IDLE, L_DONE, L_ERROR: begin
            if (w_rx_byte == MAGIC) begin
              r_sum      <= '0;
              r_word_idx <= '0;
              r_byte_cnt <= '0;
            end
          end
          L_LEN0: begin
            r_len[7:0] <= w_rx_byte;
            r_sum      <= w_rx_byte;
          end
          L_LEN1: begin
            r_len[15:8] <= w_rx_byte;
            r_sum       <= r_sum + w_rx_byte;
          end
          L_DATA: begin
            r_sum      <= r_sum + w_rx_byte;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            // Only a completed word reaches memory; partial bytes live in r_word
            if (r_byte_cnt == 2'd3) begin
              r_wr_en    <= 1'b1;
              r_wr_addr  <= {r_word_idx, 2'b00};
              r_wr_data  <= {w_rx_byte, r_word};
              r_word_idx <= r_word_idx + WW'(1);
            end else
              r_word[{r_byte_cnt, 3'b000} +: 8] <= w_rx_byte;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_core_rst_n = (r_ld_state == L_DONE);
  assign o_done       = (r_ld_state == L_DONE);
  assign o_error      = (r_ld_state == L_ERROR);
  assign o_busy       = w_in_frame;

endmodule

// File: doc/rv32i_uart_loader.md
# rv32i_uart_loader

Boot loader that sits upstream of the SoC instruction memory. It receives a framed program image over a UART RX line and writes it as aligned 32-bit words into the instruction-memory write port. It holds the RV32I core in reset until a complete image with a valid checksum has been stored.

## Interface
- `CLKS_PER_BIT`, default 868: clk cycles per UART bit (100 MHz / 115200); must be ≥4.
- `ROM_BYTES`, default 1024: instruction memory size in bytes; `AW = $clog2(ROM_BYTES)`.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `uart_rx`  in  1  serial input, idle high, 8N1, LSB first; asynchronous to clk.
- `wr_en`  out  1  one-cycle instruction-memory write strobe.
- `wr_addr`  out  AW  byte address of the word being written; bits [1:0] are always 0.
- `wr_data`  out  32  word to write, assembled little-endian.
- `core_rst_n`  out  1  active-low reset to the rv32i_core; low while loading.
- `busy`  out  1  high from magic byte accepted until DONE or ERROR.
- `done`  out  1  image loaded and verified.
- `error`  out  1  last load failed; sticky until the next magic byte.

## Operation
- **Frame format:** `0xA5`, then LEN_LO, LEN_HI (16-bit word count N), then 4·N payload bytes (word k occupies bytes b0..b3, with b0 = [7:0]), then CSUM.
- **Checksum:** CSUM = (LEN_LO + LEN_HI + all payload bytes) mod 256.
- **RX front end:**
  - 2-flop synchronizer on `uart_rx`.
  - A falling edge starts a bit counter. Sample at CLKS_PER_BIT/2; if the line is high there, treat it as a glitch and return to idle with no byte.
  - Sample 8 data bits at one-bit intervals.
  - Stop-bit sample = 0 is a framing error: no byte is delivered and `frame_err` pulses.
  - A good stop bit produces a one-cycle internal `byte_vld` with the byte.
- **Loader FSM states:** IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
- **Transitions:**
  - IDLE: `0xA5` → LEN0; any other byte is ignored.
  - LEN0 → LEN1 on the next byte.
  - LEN1 → DATA if N≥1; → CSUM if N=0; → ERROR if N > ROM_BYTES/4.
  - DATA: byte counter 0..3. On the 4th byte, write the word and advance the word index. After word N−1 is written → CSUM.
  - CSUM: match → DONE; mismatch → ERROR.
  - DONE or ERROR: a `0xA5` byte → LEN0. `error` and `done` clear, `core_rst_n` drops, the word index and running sum reset.
  - `frame_err` in any state other than IDLE/DONE/ERROR → ERROR.
- **Outputs by state:**
  - `core_rst_n` = 1 only in DONE.
  - `busy` = 1 in LEN0, LEN1, DATA, CSUM.
  - `error` = 1 in ERROR.
- **Memory contents:** words already written before an ERROR stay in memory. No partial word is ever written.
- **Reset values:** `wr_en`=0, `wr_addr`=0, `wr_data`=0, `core_rst_n`=0, `busy`=0, `done`=0, `error`=0; FSM=IDLE; RX idle.
- **Reset mid-operation:** everything returns to reset values asynchronously. The next frame must start with `0xA5`.

## Timing
- RX latency: `byte_vld` occurs at the stop-bit mid-sample, about 9.5·CLKS_PER_BIT + 2 cycles after the start edge.
- Write latency: `wr_en` is high for exactly one cycle, the cycle after the `byte_vld` of a word's 4th byte. `wr_addr` = 4·k and `wr_data` are valid in that same cycle.
- Completion: `done`, `core_rst_n`, `busy` and `error` update in the cycle after the CSUM `byte_vld`.
- No back-pressure: the memory must accept one write per cycle. Writes are spaced at least 40·CLKS_PER_BIT apart.
- Word index width is AW−2. The check N ≤ ROM_BYTES/4 guarantees the index never wraps. N = ROM_BYTES/4 is legal, and its last write goes to ROM_BYTES−4.

## Test plan
- **Normal load** (CLKS_PER_BIT=4, ROM_BYTES=1024): send A5 02 00 13 00 00 00 93 00 10 00 CSUM=0xB8 → writes (0x000, 0x00000013), (0x004, 0x00100093); one `wr_en` pulse each; then `done`=1, `core_rst_n`=1, `error`=0.
- **Bad checksum:** the same frame with CSUM=0xB9 → both writes occur, then `error`=1, `core_rst_n` stays 0. A subsequent valid frame → `done`=1, `error`=0.
- **Oversize and empty:** A5 01 01 (N=257) → ERROR with no writes. A5 00 00 00 → DONE with zero writes.
- **Line noise:**
  - Bytes 0x55 0xFF before A5 are ignored.
  - A 1-cycle low glitch on `uart_rx` produces no byte.
  - A stop bit forced low during DATA → ERROR, and the partial word is not written.
- **Reload and reset:**
  - In DONE, sending A5 → `core_rst_n`=0 and `busy`=1 within one cycle of `byte_vld`.
  - Asserting `rst_n` low mid-DATA → all outputs at reset values immediately, without waiting for a clk edge.
